// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
//   Shared definitions for the FIFO read-side drain block.
//   - ST_* : 3-bit binary state codes for the drain FSM
//   - drain_state_t : enum built on those codes
//   - clog2() : width helper used to size the acknowledge timer
package fifo_drain_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_POP       = 3'd1;
   localparam logic [2:0] ST_HANDOFF   = 3'd2;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_POP       = ST_POP,
      S_HANDOFF   = ST_HANDOFF,
      S_WAIT_BUSY = ST_WAIT_BUSY,
      S_WAIT_DONE = ST_WAIT_DONE
   } drain_state_t;

   // Bits needed to count 0..value-1; never less than 1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) w = i + 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/drain_ack_timer.sv
// drain_ack_timer
//   Counts cycles spent waiting for the transmitter to raise BUSY.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     clr      : zero the count (held while the FSM is in HANDOFF)
//     en       : count one cycle (FSM in WAIT_BUSY)
//     expire   : count has reached ACK_TIMEOUT-1
module drain_ack_timer
   import fifo_drain_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int             TW   = clog2(ACK_TIMEOUT);
   localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

   logic [TW-1:0] cnt;

   // Stops at LAST so a stalled FSM can never wrap the count.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && (cnt != LAST))
         cnt <= cnt + TW'(1);
   end

   assign expire = (cnt == LAST);

endmodule

// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain
//   Read-domain consumer of the async FIFO. Pops one word at a time and hands it
//   to a serial transmitter over a DATA_VALID/BUSY handshake; a transmitter that
//   never raises BUSY is reported on ERR_TIMEOUT and the word is dropped.
//   Optional build macro: FIFO_DRAIN_STATS_EN adds the WORD_CNT port/counter.
//   Ports:
//     CLK, RST       : read clock, synchronous active-high reset
//     EN             : drain enable (gates new pops only)
//     EMPTY, RD_DATA : FIFO status and head word
//     R_INC          : FIFO pop strobe
//     TX_BUSY        : transmitter busy
//     TX_P_DATA      : registered word to transmitter
//     TX_DATA_VALID  : one-cycle handoff strobe
//     ERR_TIMEOUT    : one-cycle pulse when BUSY never rose
//     IDLE           : FSM in IDLE
//     WORD_CNT       : delivered-word count (FIFO_DRAIN_STATS_EN only)
module fifo_tx_drain
   import fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ACK_TIMEOUT = 15
`ifdef FIFO_DRAIN_STATS_EN
  ,parameter int CNT_WIDTH   = 16
`endif
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  R_INC,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_DATA_VALID,
   output logic                  ERR_TIMEOUT,
   output logic                  IDLE
`ifdef FIFO_DRAIN_STATS_EN
  ,output logic [CNT_WIDTH-1:0]  WORD_CNT
`endif
);

   drain_state_t state;
   logic         tmr_clr, tmr_en, tmr_expire;

   assign tmr_clr = (state == S_HANDOFF);
   assign tmr_en  = (state == S_WAIT_BUSY);

   drain_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
      .clk    (CLK),
      .rst    (RST),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   // Outputs are set on the edge that enters the state they belong to, so
   // R_INC is high exactly during POP and TX_DATA_VALID exactly during HANDOFF.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         R_INC         <= 1'b0;
         TX_DATA_VALID <= 1'b0;
         TX_P_DATA     <= '0;
         ERR_TIMEOUT   <= 1'b0;
         IDLE          <= 1'b1;
      end else begin
         R_INC         <= 1'b0;
         TX_DATA_VALID <= 1'b0;
         ERR_TIMEOUT   <= 1'b0;
         case (state)
            S_IDLE: begin
               // TX_BUSY gate keeps us from popping while a frame is still out.
               if (EN && !EMPTY && !TX_BUSY) begin
                  TX_P_DATA <= RD_DATA;
                  R_INC     <= 1'b1;
                  IDLE      <= 1'b0;
                  state     <= S_POP;
               end
            end
            S_POP: begin
               TX_DATA_VALID <= 1'b1;
               state         <= S_HANDOFF;
            end
            S_HANDOFF: state <= S_WAIT_BUSY;
            S_WAIT_BUSY: begin
               if (TX_BUSY)
                  state <= S_WAIT_DONE;
               else if (tmr_expire) begin
                  // Word already left the FIFO; it is simply dropped.
                  ERR_TIMEOUT <= 1'b1;
                  IDLE        <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_WAIT_DONE: begin
               if (!TX_BUSY) begin
                  IDLE  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: begin
               IDLE  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef FIFO_DRAIN_STATS_EN
   // Counts acknowledged words only; saturates instead of wrapping.
   always_ff @(posedge CLK) begin
      if (RST)
         WORD_CNT <= '0;
      else if ((state == S_WAIT_BUSY) && TX_BUSY && (WORD_CNT != '1))
         WORD_CNT <= WORD_CNT + CNT_WIDTH'(1);
   end
`endif

endmodule
